floo_hbm_latency_responder: RTL and testbench



---
 rtl/floo_hbm_latency_responder.sv | 134 +++++++++++++
 tb/tb_floo_hbm_latency_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_hbm_latency_responder.sv
// Fixed-latency memory responder standing in for an HBM channel.
// Requests act on a local word memory at acceptance; responses leave in order once their latency has elapsed.
module floo_hbm_latency_responder #(
  parameter int unsigned Latency        = 100,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned NumWords       = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [IdWidth-1:0]     req_id_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_write_o,
  output logic [IdWidth-1:0]     rsp_id_o,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o
);

  localparam int unsigned StrbW  = DataWidth / 8;
  localparam int unsigned OffW   = $clog2(StrbW);
  localparam int unsigned IdxW   = $clog2(NumWords);
  localparam int unsigned PtrW   = $clog2(MaxOutstanding);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = $clog2(Latency + 1);

  // The accept edge itself counts as the first elapsed cycle, so the slot is
  // loaded with Latency-1 and reaches zero Latency cycles after acceptance.
  localparam logic [CntW-1:0]   LoadCd  = CntW'(Latency - 1);
  localparam logic [CountW-1:0] FullCnt = CountW'(MaxOutstanding);

  logic [DataWidth-1:0] mem [NumWords];

  logic                 slot_write [MaxOutstanding];
  logic [IdWidth-1:0]   slot_id    [MaxOutstanding];
  logic [DataWidth-1:0] slot_rdata [MaxOutstanding];
  logic                 slot_err   [MaxOutstanding];
  logic [CntW-1:0]      slot_cd    [MaxOutstanding];

  logic [PtrW-1:0]   wptr;
  logic [PtrW-1:0]   rptr;
  logic [CountW-1:0] count;

  logic [IdxW-1:0] idx;
  logic            addr_err;
  logic            accept;
  logic            pop;
  logic            empty;
  logic            head_live;

  assign idx      = req_addr_i[OffW +: IdxW];
  assign addr_err = (req_addr_i >> (OffW + IdxW)) != '0;

  assign empty       = (count == '0);
  assign req_ready_o = (count < FullCnt);
  assign accept      = req_valid_i & req_ready_o;

  assign head_live   = !empty && (slot_cd[rptr] == '0);
  assign rsp_valid_o = head_live;
  assign pop         = head_live & rsp_ready_i;

  // Response fields are forced to zero whenever nothing is presented
  assign rsp_write_o = head_live & slot_write[rptr];
  assign rsp_err_o   = head_live & slot_err[rptr];
  assign rsp_id_o    = head_live ? slot_id[rptr]    : '0;
  assign rsp_rdata_o = head_live ? slot_rdata[rptr] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < int'(NumWords); w++) begin
        mem[w] <= '0;
      end
    end else if (accept && req_write_i && !addr_err) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (req_strb_i[b]) begin
          mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Payload slots carry no reset; only occupied slots are ever presented.
  // The read sees the memory word as it was before this edge.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      slot_write[wptr] <= req_write_i;
      slot_id[wptr]    <= req_id_i;
      slot_err[wptr]   <= addr_err;
      slot_rdata[wptr] <= (!req_write_i && !addr_err) ? mem[idx] : '0;
    end
  end

  // Every slot ages on its own, so entries stuck behind a stalled head keep counting
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < int'(MaxOutstanding); s++) begin
      if (rst_i) begin
        slot_cd[s] <= '0;
      end else if (accept && (wptr == PtrW'(s))) begin
        slot_cd[s] <= LoadCd;
      end else if (slot_cd[s] != '0) begin
        slot_cd[s] <= slot_cd[s] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + PtrW'(1);
      end
      if (pop) begin
        rptr <= rptr + PtrW'(1);
      end
      unique case ({accept, pop})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_floo_hbm_latency_responder.sv
// Scoreboard bench for floo_hbm_latency_responder: the driver queues hand-computed expectations,
// and a negedge monitor checks each presented response for content, ordering, latency and stability.
module tb_floo_hbm_latency_responder;

  localparam int LAT  = 6;
  localparam int MAXO = 8;
  localparam int AW   = 48;
  localparam int DW   = 64;
  localparam int IW   = 4;
  localparam int NW   = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] req_id;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  floo_hbm_latency_responder #(
    .Latency(LAT), .MaxOutstanding(MAXO), .AddrWidth(AW),
    .DataWidth(DW), .IdWidth(IW), .NumWords(NW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_id_i(req_id), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_id_o(rsp_id), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [IW-1:0] id;
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
    bit            exact;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   accepted = 0;
  bit   drv_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one request starting just after a rising edge and returns just after its accept edge
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [IW-1:0] id,
                       input logic [DW-1:0] wd, input logic [7:0] st,
                       input logic [DW-1:0] er, input logic ee, input bit exact);
    exp_t e;
    int   waitc = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_id    = id;
    req_wdata = wd;
    req_strb  = st;
    @(negedge clk);
    while (!req_ready) begin
      waitc++;
      if (waitc > 200) begin
        chk("req_ready_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.wr    = w;
    e.id    = id;
    e.rdata = er;
    e.err   = ee;
    e.acc   = cyc;
    e.exact = exact;
    q.push_back(e);
    accepted++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor
  initial begin
    logic          stalled = 1'b0;
    logic          presenting = 1'b0;
    logic          s_write;
    logic          s_err;
    logic [IW-1:0] s_id;
    logic [DW-1:0] s_rdata;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled    = 1'b0;
        presenting = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 64'(rsp_valid), 64'd1);
          chk("stall_write", 64'(rsp_write), 64'(s_write));
          chk("stall_id",    64'(rsp_id),    64'(s_id));
          chk("stall_rdata", rsp_rdata,      s_rdata);
          chk("stall_err",   64'(rsp_err),   64'(s_err));
        end
        if (!rsp_valid) begin
          chk("idle_fields_zero",
              64'(rsp_write | rsp_err | (|rsp_id) | (|rsp_rdata)), 64'd0);
        end else if (q.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = q[0];
          if (!presenting) begin
            if (e.exact) chk("latency", 64'(cyc - e.acc), 64'(LAT));
            else         chk("latency_min", 64'((cyc - e.acc) >= LAT), 64'd1);
            chk("rsp_write", 64'(rsp_write), 64'(e.wr));
            chk("rsp_id",    64'(rsp_id),    64'(e.id));
            chk("rsp_rdata", rsp_rdata,      e.rdata);
            chk("rsp_err",   64'(rsp_err),   64'(e.err));
          end
          if (rsp_ready) begin
            void'(q.pop_front());
            presenting = 1'b0;
          end else begin
            presenting = 1'b1;
          end
        end
        stalled = rsp_valid && !rsp_ready;
        s_write = rsp_write;
        s_err   = rsp_err;
        s_id    = rsp_id;
        s_rdata = rsp_rdata;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_id    = '0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_write", 64'(rsp_write), 64'd0);
    chk("reset_rsp_id",    64'(rsp_id),    64'd0);
    chk("reset_rsp_rdata", rsp_rdata,      64'd0);
    chk("reset_rsp_err",   64'(rsp_err),   64'd0);
    @(posedge clk);
    #1;

    // Full write then back-to-back read of the same word
    issue(1'b1, 48'h40, 4'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'd0, 1'b0, 1'b1);
    issue(1'b0, 48'h40, 4'd5, 64'd0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
    drain();

    // Partial strobe on word 0, and low address bits ignored
    issue(1'b1, 48'h0,  4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0, 1'b0, 1'b1);
    issue(1'b0, 48'h0,  4'd2, 64'd0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    issue(1'b0, 48'h45, 4'd9, 64'd0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
    drain();

    // Out-of-range read and write; the write must not alias onto word 0
    issue(1'b0, 48'h1_0000_0000, 4'd7, 64'd0, 8'h00, 64'd0, 1'b1, 1'b1);
    issue(1'b1, 48'h1_0000_0000, 4'd6, 64'h1234_5678_9ABC_DEF0, 8'hFF, 64'd0, 1'b1, 1'b1);
    issue(1'b0, 48'h0, 4'd1, 64'd0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    drain();

    // Fill to capacity under backpressure, then release
    rsp_ready = 1'b0;
    accepted  = 0;
    drv_done  = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          issue(1'b0, (i % 2 == 0) ? 48'h40 : 48'h0, IW'(i), 64'd0, 8'h00,
                (i % 2 == 0) ? 64'hDEAD_BEEF_0123_4567 : 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        end
        drv_done = 1'b1;
      end
    join_none
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("accepted_at_full", 64'(accepted), 64'd8);
    chk("ready_at_full", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    begin
      int n = 0;
      while (!drv_done && n < 300) begin
        @(posedge clk);
        n++;
      end
    end
    #1;
    chk("driver_done", 64'(drv_done), 64'd1);
    chk("accepted_total", 64'(accepted), 64'd10);
    drain();

    // Reset with four reads in flight: none may ever respond
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 48'h40, IW'(8 + i), 64'd0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
    end
    q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    issue(1'b0, 48'h40, 4'd4, 64'd0, 8'h00, 64'd0, 1'b0, 1'b1);
    issue(1'b0, 48'h0,  4'd3, 64'd0, 8'h00, 64'd0, 1'b0, 1'b1);
    drain();

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty_at_end", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
